// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel console command sequencer:
// command codes, key_in bit positions and sequencer state encoding.
package panel_pkg;

   localparam logic [2:0] CMD_START     = 3'd0;
   localparam logic [2:0] CMD_LOAD_ADDR = 3'd1;
   localparam logic [2:0] CMD_DEP       = 3'd2;
   localparam logic [2:0] CMD_EXAM      = 3'd3;
   localparam logic [2:0] CMD_CONT      = 3'd4;
   localparam logic [2:0] CMD_STOP      = 3'd5;

   localparam int KEY_START     = 7;
   localparam int KEY_LOAD_ADDR = 6;
   localparam int KEY_DEP       = 5;
   localparam int KEY_EXAM      = 4;
   localparam int KEY_CONT      = 3;
   localparam int KEY_STOP      = 2;
   localparam int KEY_SING_STEP = 1;
   localparam int KEY_SING_INST = 0;
   localparam int KEY_CMD_LSB   = KEY_STOP;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/panel_key_ctl_if.sv
// Console command handshake between the panel sequencer (master) and the CPU
// control logic (slave).
interface panel_key_ctl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_code;
   logic       cmd_reject;

   modport master (output cmd_valid, output cmd_code, output cmd_reject, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_code, input cmd_reject, output cmd_ready);
endinterface

// File: rtl/key_prio_enc.sv
// Fixed-priority encoder for command key presses (vector indexed from key_in[2]).
// STOP > START > CONT > LOAD_ADDR > EXAM > DEP.
module key_prio_enc
   import panel_pkg::*;
(
   input  logic [5:0] press_i,
   output logic       hit_o,
   output logic [2:0] code_o
);

   always_comb begin
      hit_o  = |press_i;
      code_o = CMD_DEP;
      if (press_i[KEY_STOP - KEY_CMD_LSB])
         code_o = CMD_STOP;
      else if (press_i[KEY_START - KEY_CMD_LSB])
         code_o = CMD_START;
      else if (press_i[KEY_CONT - KEY_CMD_LSB])
         code_o = CMD_CONT;
      else if (press_i[KEY_LOAD_ADDR - KEY_CMD_LSB])
         code_o = CMD_LOAD_ADDR;
      else if (press_i[KEY_EXAM - KEY_CMD_LSB])
         code_o = CMD_EXAM;
      else if (press_i[KEY_DEP - KEY_CMD_LSB])
         code_o = CMD_DEP;
   end

endmodule

// File: rtl/panel_key_ctl.sv
// Panel key press -> console command sequencer with run-state qualification.
// Define PANEL_AUTOREPEAT_EN to build DEP/EXAM autorepeat while the key is held.
module panel_key_ctl
   import panel_pkg::*;
#(
   parameter int REPEAT_DELAY = 50000000,
   parameter int REPEAT_RATE  = 10000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        key_in,
   input  logic              run,
   panel_key_ctl_if.master   cmd,
   output logic              sing_step_q,
   output logic              sing_inst_q
);

   state_e     state_q, state_d;
   logic [2:0] code_q, code_d;
   logic       reject_q, reject_d;
   logic [5:0] prev_q;
   logic [5:0] cmd_keys;
   logic [5:0] press;
   logic       enc_hit;
   logic [2:0] enc_code;

   assign cmd_keys = key_in[KEY_START:KEY_CMD_LSB];
   assign press    = cmd_keys & ~prev_q;

   key_prio_enc u_prio (
      .press_i (press),
      .hit_o   (enc_hit),
      .code_o  (enc_code)
   );

`ifdef PANEL_AUTOREPEAT_EN
   localparam int CNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   cnt_inc;
   logic [CNT_W:0]   rep_thr;
   logic             arm_q, arm_d;
   logic             rep_q, rep_d;
   logic             key_held;

   // Counter value counts cycles since the transfer, the transfer cycle included.
   assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
   assign rep_thr  = rep_q ? (CNT_W+1)'(REPEAT_RATE) : (CNT_W+1)'(REPEAT_DELAY);
   assign key_held = (code_q == CMD_DEP  && key_in[KEY_DEP]) ||
                     (code_q == CMD_EXAM && key_in[KEY_EXAM]);
`endif

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      reject_d = 1'b0;
`ifdef PANEL_AUTOREPEAT_EN
      cnt_d    = cnt_q;
      arm_d    = arm_q;
      rep_d    = rep_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (enc_hit) begin
               if (run && enc_code != CMD_STOP) begin
                  reject_d = 1'b1;
               end else begin
                  state_d = ST_ISSUE;
                  code_d  = enc_code;
`ifdef PANEL_AUTOREPEAT_EN
                  rep_d   = 1'b0;
`endif
               end
            end
         end
         ST_ISSUE: begin
            if (cmd.cmd_ready) begin
               state_d = ST_HOLD;
`ifdef PANEL_AUTOREPEAT_EN
               cnt_d   = CNT_W'(1);
               arm_d   = 1'b1;
`endif
            end
         end
         ST_HOLD: begin
            // STOP is the only press honoured while a key is still down.
            if (enc_hit && enc_code == CMD_STOP) begin
               state_d = ST_ISSUE;
               code_d  = CMD_STOP;
`ifdef PANEL_AUTOREPEAT_EN
               rep_d   = 1'b0;
`endif
            end else if (cmd_keys == '0) begin
               state_d = ST_IDLE;
            end
`ifdef PANEL_AUTOREPEAT_EN
            else if (!arm_q || !key_held || run) begin
               arm_d = 1'b0;
            end else if (cnt_inc >= rep_thr) begin
               state_d = ST_ISSUE;
               rep_d   = 1'b1;
            end else begin
               cnt_d = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // Loaded during reset too, so keys held through reset never fire.
      prev_q <= cmd_keys;
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         code_q      <= '0;
         reject_q    <= 1'b0;
         sing_step_q <= 1'b0;
         sing_inst_q <= 1'b0;
`ifdef PANEL_AUTOREPEAT_EN
         cnt_q       <= '0;
         arm_q       <= 1'b0;
         rep_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         reject_q    <= reject_d;
         sing_step_q <= key_in[KEY_SING_STEP];
         sing_inst_q <= key_in[KEY_SING_INST];
`ifdef PANEL_AUTOREPEAT_EN
         cnt_q       <= cnt_d;
         arm_q       <= arm_d;
         rep_q       <= rep_d;
`endif
      end
   end

   assign cmd.cmd_valid  = (state_q == ST_ISSUE);
   assign cmd.cmd_code   = code_q;
   assign cmd.cmd_reject = reject_q;

endmodule

// File: doc/panel_key_ctl.md
# panel_key_ctl

Console command sequencer between the front-panel scanner/debouncer and the CPU control logic. Takes debounced, active-high panel key levels, converts key presses into single console commands with priority and run-state qualification, and delivers them over a valid/ready handshake. Also registers the SING STEP / SING INST mode switches for the CPU.

## Interface

Parameters:
- REPEAT_DELAY, 50000000: cycles a DEP/EXAM key must stay held after its first transfer before the first repeat (autorepeat builds only).
- REPEAT_RATE, 10000000: cycles between subsequent repeats (autorepeat builds only).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- key_in  in  8  debounced key levels {start, load_addr, dep, exam, cont, stop, sing_step, sing_inst}, 1 = pressed.
- run  in  1  CPU run flip-flop.
- cmd_ready  in  1  CPU accepts the command.
- cmd_valid  out  1  command offered.
- cmd_code  out  3  START=0, LOAD_ADDR=1, DEP=2, EXAM=3, CONT=4, STOP=5.
- cmd_reject  out  1  one-cycle pulse when a press is refused.
- sing_step_q  out  1  registered key_in[1].
- sing_inst_q  out  1  registered key_in[0].

## Operation

- Command keys are key_in[7:2]; mode switches key_in[1:0] are registered every cycle and never produce commands.
- Edge detect: press = key_in[7:2] & ~prev; prev updates every cycle.
- Priority among simultaneous presses: STOP > START > CONT > LOAD_ADDR > EXAM > DEP. Lower-priority simultaneous presses are discarded silently.
- Qualification: while run=1, only STOP is accepted. Any other winning press pulses cmd_reject and the state is unchanged. While run=0, all commands are accepted, including STOP.
- States:
  - IDLE: on an accepted press, latch cmd_code, go to ISSUE.
  - ISSUE: cmd_valid=1 and cmd_code is held stable. When cmd_valid & cmd_ready are high at a clock edge, go to HOLD.
  - HOLD: wait until key_in[7:2]==0, then go to IDLE. In this state, a STOP rising edge is qualified as in IDLE and goes to ISSUE with STOP. All other presses in HOLD are dropped without a reject.
- A press arriving during ISSUE is dropped, including STOP. The in-flight command is never replaced.
- Reset, synchronous, while rst_n=0:
  - state = IDLE; cmd_valid, cmd_code, cmd_reject, sing_step_q, sing_inst_q = 0.
  - prev loads key_in, so keys held through reset do not fire on reset release.
  - Reset asserted mid-ISSUE drops the command without a transfer.

## Timing

- Press seen on key_in at edge n → cmd_valid high after edge n+1, i.e. 1 cycle of latency. cmd_reject pulses in the same cycle slot.
- Transfer at the edge where cmd_valid & cmd_ready are both high; cmd_valid is low the following cycle.
- cmd_ready may be held high permanently, giving a 1-cycle valid pulse.
- HOLD → IDLE takes 1 cycle after all command keys read 0. A new press can be accepted on the edge after that.
- sing_step_q / sing_inst_q lag key_in by 1 cycle.
- Repeat counter: width clog2(max(REPEAT_DELAY, REPEAT_RATE)+1), saturating; it does not wrap.

## Configuration

- PANEL_AUTOREPEAT_EN defined:
  - In HOLD with the latched command DEP or EXAM, and its key still held, the counter runs from the transfer.
  - When it reaches REPEAT_DELAY for the first repeat, or REPEAT_RATE for later repeats, the block re-enters ISSUE with the same code.
  - The counter clears on each transfer. Release of the key or a STOP press cancels the repeat.
  - Repeats are suppressed while run=1.
- Undefined: no counter is built. HOLD only waits for release, and exactly one command is issued per press.

## Structure

- The shared package panel_pkg holds:
  - the command code localparams (CMD_START … CMD_STOP);
  - the key_in bit-index constants;
  - the state encoding (ST_IDLE, ST_ISSUE, ST_HOLD).
- Sub-module key_prio_enc: combinational 6-bit press vector → {hit, 3-bit code} using the fixed priority. It is instantiated once.

## Test plan

Sim parameters: REPEAT_DELAY=20, REPEAT_RATE=5.

- Reset release with key_in=8'h80 held → no cmd_valid. Release, then press 8'h80 with run=0 → cmd_valid=1, cmd_code=0 one cycle later; cmd_ready=1 gives a single-cycle valid.
- Simultaneous press 8'hFC, run=0 → cmd_code=5 only. Hold the keys, then press 8'h20 again without a full release → no new command.
- run=1, press LOAD_ADDR (8'h40) → cmd_reject one cycle, cmd_valid stays 0. Press STOP (8'h04) → cmd_code=5 issued.
- cmd_ready=0 for 10 cycles during ISSUE with EXAM (code 3), plus a CONT press meanwhile → cmd_code stays 3 and no CONT is issued. Raise cmd_ready → one transfer.
- PANEL_AUTOREPEAT_EN, DEP (8'h20) held 50 cycles, cmd_ready=1 → transfers at ~t=1, 21, 26, 31, 36, 41, 46. Without the macro → one transfer.
- rst_n low during ISSUE → cmd_valid=0 the next cycle and no transfer. After release, state is IDLE and sing_step_q/sing_inst_q track key_in[1:0] with 1-cycle lag.
